kb_param_ctrl: RTL and testbench
================================

KB_PARAM_CTRL -- requirements
Module: kb_param_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: maximum decimal digits per entry.
REQ-002 SHALL have parameter NSLOT, default 4: number of configuration slots (power of 2).
REQ-003 SHALL have port clk, input, 1: single system clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port kb_buf_empty, input, 1: keyboard FIFO empty flag.
REQ-006 SHALL have port key_code, input, 8: FIFO head scan code (set 2), valid while kb_buf_empty=0.
REQ-007 SHALL have port rd_key_code, output, 1: one-cycle FIFO pop strobe.
REQ-008 SHALL have port next_key, input, 1: one-cycle pulse, advance slot.
REQ-009 SHALL have port cfg_wr, output, 1: write request to DSP parameter bank.
REQ-010 SHALL have port cfg_ack, input, 1: bank accepted write.
REQ-011 SHALL have port cfg_addr, output, log2(NSLOT): target slot.
REQ-012 SHALL have port cfg_data, output, 4*DIGITS: committed value, packed BCD, digit 0 in LSBs.
REQ-013 SHALL have port entry_bcd, output, 4*DIGITS: live entry for display.
REQ-014 SHALL have port digit_cnt, output, log2(DIGITS)+1: digits currently entered.
REQ-015 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-016 SHALL have port err, output, 1: one-cycle pulse on rejected key.

Function
REQ-017 SHALL implement states IDLE, POP, DECODE, WRITE.
REQ-018 IDLE: if kb_buf_empty=0, capture key_code into key_reg and go to POP; else stay.
REQ-019 POP: assert rd_key_code for exactly one cycle, then go to DECODE; rd_key_code SHALL be 0 in all other states.
REQ-020 DECODE, digit keys (0=45h, 1=16h, 2=1Eh, 3=26h, 4=25h, 5=2Eh, 6=36h, 7=3Dh, 8=3Eh, 9=46h): if digit_cnt<DIGITS, shift entry_bcd left 4 bits, insert digit in LSBs, increment digit_cnt; else pulse err, entry unchanged; go to IDLE.
REQ-021 DECODE, Backspace (66h): if digit_cnt>0, shift entry_bcd right 4 bits (zero fill), decrement digit_cnt; else no change, no err; go to IDLE.
REQ-022 DECODE, Esc (76h): clear entry_bcd and digit_cnt; go to IDLE.
REQ-023 DECODE, Enter (5Ah): if digit_cnt>0, load cfg_data<=entry_bcd and cfg_addr<=slot, clear entry, go to WRITE; if digit_cnt=0, pulse err, go to IDLE.
REQ-024 DECODE, any other code: pulse err, go to IDLE.
REQ-025 WRITE: hold cfg_wr=1, cfg_addr and cfg_data stable until cfg_ack=1; on the cfg_ack cycle drop cfg_wr next cycle and go to IDLE; no timeout.
REQ-026 cfg_ack outside WRITE SHALL be ignored.
REQ-027 next_key in IDLE, POP or DECODE: slot<=(slot+1) mod NSLOT and clear entry; wraps NSLOT-1 to 0.
REQ-028 next_key in WRITE: set pending flag; apply advance and clear on the cycle after leaving WRITE; further pulses while pending collapse into one.
REQ-029 next_key coincident with an Enter in DECODE: commit uses the pre-advance slot, then advance applies; committed entry is cleared.
REQ-030 next_key coincident with a digit/Backspace in DECODE: advance and clear win; the key has no effect.
REQ-031 FIFO SHALL never be popped while kb_buf_empty=1; throughput is at most one key per 3 cycles.
REQ-032 cfg_addr SHALL always equal the current slot outside WRITE.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE, slot=0, entry_bcd=0, digit_cnt=0, cfg_data=0, cfg_addr=0, pending=0, and rd_key_code, cfg_wr, err, busy all 0.
REQ-034 reset asserted during WRITE SHALL drop cfg_wr without waiting for cfg_ack; the write is abandoned.

Verification
REQ-035 Keys 16h, 1Eh, 26h, 5Ah with cfg_ack 2 cycles after cfg_wr -> cfg_wr=1 with cfg_addr=0 and cfg_data=0123h held until ack; entry_bcd=0 and digit_cnt=0 afterwards; one rd_key_code per key.
REQ-036 Five digit keys 16h then 66h -> err once on the 5th digit; after 66h entry_bcd=0123h, digit_cnt=3.
REQ-037 next_key pulsed 5 times in IDLE with NSLOT=4 -> cfg_addr=1; an Enter with an empty entry -> err pulse, no cfg_wr.
REQ-038 next_key during WRITE with ack withheld 10 cycles -> cfg_addr=0 throughout the write, slot=1 the cycle after exit.
REQ-039 reset low mid-WRITE -> cfg_wr=0 immediately; all outputs at reset values; no FIFO pop while kb_buf_empty=1.

Source files
------------

// File: rtl/kb_param_ctrl_if.sv
// Bus bundle for kb_param_ctrl: keyboard FIFO read side plus the DSP parameter-bank write port.
// master = controller, slave = environment (FIFO + parameter bank).
interface kb_param_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int NSLOT  = 4
);
  logic                     kb_buf_empty;
  logic [7:0]               key_code;
  logic                     rd_key_code;
  logic                     cfg_wr;
  logic                     cfg_ack;
  logic [$clog2(NSLOT)-1:0] cfg_addr;
  logic [4*DIGITS-1:0]      cfg_data;

  modport master (
    input  kb_buf_empty, key_code, cfg_ack,
    output rd_key_code, cfg_wr, cfg_addr, cfg_data
  );

  modport slave (
    output kb_buf_empty, key_code, cfg_ack,
    input  rd_key_code, cfg_wr, cfg_addr, cfg_data
  );
endinterface

// File: rtl/kb_param_ctrl.sv
// Keypad entry controller: collects decimal digits from a PS/2 FIFO and commits them
// as packed BCD to one of NSLOT parameter-bank slots. NSLOT must be a power of 2, >= 2.
//
//   state  | meaning
//   IDLE   | wait for a key in the FIFO; apply pending slot advance
//   POP    | rd_key_code strobe, key already latched
//   DECODE | act on the latched key
//   WRITE  | hold cfg_wr/cfg_addr/cfg_data until cfg_ack
module kb_param_ctrl #(
  parameter int DIGITS = 4,
  parameter int NSLOT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  kb_param_ctrl_if.master          bus,
  input  logic                     next_key,
  output logic [4*DIGITS-1:0]      entry_bcd,
  output logic [$clog2(DIGITS):0]  digit_cnt,
  output logic                     busy,
  output logic                     err
);
  localparam int AW = $clog2(NSLOT);
  localparam int CW = $clog2(DIGITS) + 1;
  localparam int EW = 4 * DIGITS;

  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_ESC   = 8'h76;
  localparam logic [7:0] K_ENTER = 8'h5A;

  typedef enum logic [1:0] {IDLE, POP, DECODE, WRITE} state_t;

  state_t        state_q;
  logic [7:0]    key_q;
  logic [AW-1:0] slot_q;
  logic [AW-1:0] cfg_addr_q;
  logic [EW-1:0] entry_q;
  logic [EW-1:0] cfg_data_q;
  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          rd_q;
  logic          wr_q;
  logic          err_q;

  logic          adv_d;
  logic [AW-1:0] slot_inc_d;
  logic          dig_vld_d;
  logic [3:0]    dig_d;

  always_comb begin
    adv_d      = next_key | pend_q;
    slot_inc_d = slot_q + AW'(1);
    dig_vld_d  = 1'b1;
    dig_d      = 4'd0;
    case (key_q)
      8'h45:   dig_d = 4'd0;
      8'h16:   dig_d = 4'd1;
      8'h1E:   dig_d = 4'd2;
      8'h26:   dig_d = 4'd3;
      8'h25:   dig_d = 4'd4;
      8'h2E:   dig_d = 4'd5;
      8'h36:   dig_d = 4'd6;
      8'h3D:   dig_d = 4'd7;
      8'h3E:   dig_d = 4'd8;
      8'h46:   dig_d = 4'd9;
      default: dig_vld_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      slot_q     <= '0;
      cfg_addr_q <= '0;
      entry_q    <= '0;
      cfg_data_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // pend_q only survives into the first IDLE cycle after WRITE
          if (adv_d) begin
            slot_q     <= slot_inc_d;
            cfg_addr_q <= slot_inc_d;
            entry_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
          end
          if (!bus.kb_buf_empty) begin
            key_q   <= bus.key_code;
            rd_q    <= 1'b1;
            state_q <= POP;
          end
        end
        POP: begin
          if (adv_d) begin
            slot_q     <= slot_inc_d;
            cfg_addr_q <= slot_inc_d;
            entry_q    <= '0;
            cnt_q      <= '0;
          end
          state_q <= DECODE;
        end
        DECODE: begin
          state_q <= IDLE;
          if (adv_d) begin
            slot_q  <= slot_inc_d;
            entry_q <= '0;
            cnt_q   <= '0;
          end
          if (key_q == K_ENTER) begin
            if (cnt_q != '0) begin
              // commit targets the slot as it was before any coincident advance
              cfg_data_q <= entry_q;
              cfg_addr_q <= slot_q;
              wr_q       <= 1'b1;
              entry_q    <= '0;
              cnt_q      <= '0;
              state_q    <= WRITE;
            end else begin
              err_q <= 1'b1;
              if (adv_d) cfg_addr_q <= slot_inc_d;
            end
          end else if (adv_d) begin
            cfg_addr_q <= slot_inc_d;
          end else if (dig_vld_d) begin
            if (cnt_q < CW'(DIGITS)) begin
              entry_q <= {entry_q[EW-5:0], dig_d};
              cnt_q   <= cnt_q + CW'(1);
            end else begin
              err_q <= 1'b1;
            end
          end else if (key_q == K_BKSP) begin
            if (cnt_q != '0) begin
              entry_q <= {4'h0, entry_q[EW-1:4]};
              cnt_q   <= cnt_q - CW'(1);
            end
          end else if (key_q == K_ESC) begin
            entry_q <= '0;
            cnt_q   <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        WRITE: begin
          if (next_key) pend_q <= 1'b1;
          if (bus.cfg_ack) begin
            wr_q       <= 1'b0;
            cfg_addr_q <= slot_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_key_code = rd_q;
  assign bus.cfg_wr      = wr_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.cfg_data    = cfg_data_q;
  assign entry_bcd       = entry_q;
  assign digit_cnt       = cnt_q;
  assign busy            = (state_q != IDLE);
  assign err             = err_q;
endmodule

// File: tb/tb_kb_param_ctrl.sv
// Directed bench for kb_param_ctrl: a FIFO/bank environment plus a key-level model
// (decimal value + digit count + slot) that predicts the idle-state outputs.
module tb_kb_param_ctrl;
  localparam int D = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        next_key = 1'b0;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_cnt;
  logic        busy;
  logic        err;

  kb_param_ctrl_if #(.DIGITS(D), .NSLOT(N)) bus ();

  kb_param_ctrl #(.DIGITS(D), .NSLOT(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .next_key  (next_key),
    .entry_bcd (entry_bcd),
    .digit_cnt (digit_cnt),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model state
  int          m_val = 0;
  int          m_cnt = 0;
  int          m_slot = 0;
  logic [15:0] m_cfg_data = '0;
  int          m_err = 0;
  int          m_keys = 0;
  int          m_writes = 0;
  int          m_exp_addr = 0;
  logic [15:0] m_exp_data = '0;
  bit          model_valid = 1'b0;

  // environment observations
  logic [7:0]  fifo[$];
  int          ack_delay = 2;
  int          wr_cycles = 0;
  int          rd_seen = 0;
  int          err_seen = 0;
  int          wr_seen = 0;
  logic        prev_wr = 1'b0;
  logic [1:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int x;
    b = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic int digit_of(input logic [7:0] c);
    logic [7:0] tbl [10];
    tbl = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 10; i++) if (tbl[i] == c) return i;
    return -1;
  endfunction

  task automatic model_advance();
    m_slot = (m_slot + 1) % N;
    m_val  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_key(input logic [7:0] c, input bit with_next);
    int d;
    d = digit_of(c);
    m_keys++;
    if (c == 8'h5A) begin
      if (m_cnt > 0) begin
        m_exp_addr = m_slot;
        m_exp_data = to_bcd(m_val);
        m_cfg_data = m_exp_data;
        m_writes++;
        m_val = 0;
        m_cnt = 0;
      end else begin
        m_err++;
      end
    end else if (with_next) begin
      // advance swallows the key
    end else if (d >= 0) begin
      if (m_cnt < D) begin
        m_val = m_val * 10 + d;
        m_cnt++;
      end else begin
        m_err++;
      end
    end else if (c == 8'h66) begin
      if (m_cnt > 0) begin
        m_val = m_val / 10;
        m_cnt--;
      end
    end else if (c == 8'h76) begin
      m_val = 0;
      m_cnt = 0;
    end else begin
      m_err++;
    end
    if (with_next) model_advance();
  endtask

  // FIFO front end
  always @(negedge clk) begin
    if (bus.rd_key_code) begin
      chk("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    bus.kb_buf_empty = (fifo.size() == 0);
    bus.key_code     = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // parameter bank: ack ack_delay cycles after cfg_wr rises
  always @(negedge clk) begin
    if (bus.cfg_wr) begin
      wr_cycles++;
      bus.cfg_ack = (wr_cycles == ack_delay);
    end else begin
      wr_cycles   = 0;
      bus.cfg_ack = 1'b0;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (bus.rd_key_code) rd_seen++;
    if (err) err_seen++;
    if (bus.cfg_wr && !prev_wr) wr_seen++;
    prev_wr = bus.cfg_wr;
    if (bus.cfg_wr) begin
      last_wr_addr = bus.cfg_addr;
      last_wr_data = bus.cfg_data;
      chk("wr_addr", 32'(bus.cfg_addr), 32'(m_exp_addr));
      chk("wr_data", 32'(bus.cfg_data), 32'(m_exp_data));
    end
    if (model_valid && reset && !busy) begin
      chk("entry_bcd", 32'(entry_bcd), 32'(to_bcd(m_val)));
      chk("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
      chk("cfg_addr", 32'(bus.cfg_addr), 32'(m_slot));
      chk("cfg_data", 32'(bus.cfg_data), 32'(m_cfg_data));
      chk("idle_wr", 32'(bus.cfg_wr), 32'd0);
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rd_key_code && n < 40);
    if (!bus.rd_key_code) chk({name, "_rd_timeout"}, 32'(bus.rd_key_code), 32'd1);
  endtask

  task automatic send_key(input logic [7:0] c, input bit with_next);
    model_valid = 1'b0;
    model_key(c, with_next);
    fifo.push_back(c);
    wait_rd("key");
    if (with_next) begin
      @(negedge clk) next_key = 1'b1;
      @(negedge clk) next_key = 1'b0;
    end
    wait_idle("key");
    model_valid = 1'b1;
  endtask

  task automatic pulse_next();
    model_valid = 1'b0;
    model_advance();
    @(negedge clk) next_key = 1'b1;
    @(negedge clk) next_key = 1'b0;
    model_valid = 1'b1;
  endtask

  task automatic wait_wr(input string name);
    int n;
    n = 0;
    while (!bus.cfg_wr && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cfg_wr) chk({name, "_wr_timeout"}, 32'(bus.cfg_wr), 32'd1);
  endtask

  task automatic counts(input string name);
    chk({name, "_err_cnt"}, 32'(err_seen), 32'(m_err));
    chk({name, "_rd_cnt"},  32'(rd_seen),  32'(m_keys));
    chk({name, "_wr_cnt"},  32'(wr_seen),  32'(m_writes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int w0;
    bus.kb_buf_empty = 1'b1;
    bus.key_code     = 8'h00;
    bus.cfg_ack      = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_entry", 32'(entry_bcd), 32'd0);
    chk("rst_cnt",   32'(digit_cnt), 32'd0);
    chk("rst_addr",  32'(bus.cfg_addr), 32'd0);
    chk("rst_data",  32'(bus.cfg_data), 32'd0);
    chk("rst_wr",    32'(bus.cfg_wr), 32'd0);
    chk("rst_rd",    32'(bus.rd_key_code), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    reset = 1'b1;
    model_valid = 1'b1;
    repeat (2) @(negedge clk);

    // "123" Enter to slot 0
    ack_delay = 2;
    send_key(8'h16, 0);
    send_key(8'h1E, 0);
    send_key(8'h26, 0);
    send_key(8'h5A, 0);
    chk("t1_wr_data", 32'(last_wr_data), 32'h0123);
    chk("t1_wr_addr", 32'(last_wr_addr), 32'd0);
    chk("t1_entry",   32'(entry_bcd), 32'd0);
    chk("t1_cnt",     32'(digit_cnt), 32'd0);
    chk("t1_rd",      32'(rd_seen), 32'd4);
    counts("t1");

    // overflow on the fifth digit, then backspace
    e0 = err_seen;
    send_key(8'h16, 0);
    send_key(8'h1E, 0);
    send_key(8'h26, 0);
    send_key(8'h25, 0);
    send_key(8'h2E, 0);
    send_key(8'h66, 0);
    chk("t2_err", 32'(err_seen - e0), 32'd1);
    chk("t2_entry", 32'(entry_bcd), 32'h0123);
    chk("t2_cnt", 32'(digit_cnt), 32'd3);
    send_key(8'h76, 0);
    counts("t2");

    // slot wrap and empty Enter
    repeat (5) pulse_next();
    chk("t3_addr", 32'(bus.cfg_addr), 32'd1);
    e0 = err_seen;
    w0 = wr_seen;
    send_key(8'h5A, 0);
    chk("t3_err", 32'(err_seen - e0), 32'd1);
    chk("t3_nowr", 32'(wr_seen - w0), 32'd0);
    counts("t3");

    // next_key during a long write
    repeat (3) pulse_next();
    send_key(8'h16, 0);
    send_key(8'h1E, 0);
    ack_delay = 10;
    model_valid = 1'b0;
    model_key(8'h5A, 0);
    model_advance();
    fifo.push_back(8'h5A);
    wait_wr("t4");
    repeat (2) @(negedge clk);
    next_key = 1'b1;
    @(negedge clk) next_key = 1'b0;
    @(negedge clk) next_key = 1'b1;
    @(negedge clk) next_key = 1'b0;
    wait_idle("t4");
    model_valid = 1'b1;
    chk("t4_wr_addr", 32'(last_wr_addr), 32'd0);
    chk("t4_wr_data", 32'(last_wr_data), 32'h0012);
    chk("t4_addr_after", 32'(bus.cfg_addr), 32'd1);
    counts("t4");

    // coincident next_key with a digit and with Enter
    ack_delay = 2;
    send_key(8'h26, 0);
    send_key(8'h45, 1);
    chk("t5_entry", 32'(entry_bcd), 32'd0);
    chk("t5_addr", 32'(bus.cfg_addr), 32'd2);
    send_key(8'h25, 0);
    send_key(8'h2E, 0);
    send_key(8'h5A, 1);
    chk("t5_wr_addr", 32'(last_wr_addr), 32'd2);
    chk("t5_wr_data", 32'(last_wr_data), 32'h0045);
    chk("t5_addr_after", 32'(bus.cfg_addr), 32'd3);
    counts("t5");

    // backspace when empty, unknown key
    e0 = err_seen;
    send_key(8'h66, 0);
    chk("t6_bksp_noerr", 32'(err_seen - e0), 32'd0);
    send_key(8'h1C, 0);
    chk("t6_unknown_err", 32'(err_seen - e0), 32'd1);
    counts("t6");

    // reset in the middle of a write
    send_key(8'h3D, 0);
    ack_delay = 1000;
    model_valid = 1'b0;
    model_key(8'h5A, 0);
    fifo.push_back(8'h5A);
    wait_wr("t7");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t7_wr", 32'(bus.cfg_wr), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_addr", 32'(bus.cfg_addr), 32'd0);
    chk("t7_data", 32'(bus.cfg_data), 32'd0);
    chk("t7_entry", 32'(entry_bcd), 32'd0);
    chk("t7_rd", 32'(bus.rd_key_code), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_val = 0;
    m_cnt = 0;
    m_slot = 0;
    m_cfg_data = '0;
    model_valid = 1'b1;
    repeat (3) @(negedge clk);

    // recovery after reset
    ack_delay = 2;
    send_key(8'h46, 0);
    send_key(8'h5A, 0);
    chk("t8_wr_addr", 32'(last_wr_addr), 32'd0);
    chk("t8_wr_data", 32'(last_wr_data), 32'h0009);
    counts("t8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
